// File: rtl/dac_sample_streamer.sv
// DAC sample streamer: host samples are queued in a FIFO and released one per
// programmable sample tick onto a registered DAC code bus with a strobe.
module dac_sample_streamer #(
   parameter int unsigned       DATA_W    = 10,
   parameter int unsigned       FIFO_AW   = 5,
   parameter int unsigned       CLKDIV_W  = 20,
   parameter logic [DATA_W-1:0] IDLE_CODE = {DATA_W{1'b0}}
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                mode_i,
   input  logic [CLKDIV_W-1:0] clkdiv_i,
   input  logic [FIFO_AW:0]    fifo_threshold_i,
   input  logic                wr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                flush_i,
   input  logic                flags_clr_i,
   output logic                full_o,
   output logic                empty_o,
   output logic [FIFO_AW:0]    level_o,
   output logic                low_o,
   output logic                underrun_o,
   output logic                overflow_o,
   output logic                dac_en_o,
   output logic                dac_rst_o,
   output logic [DATA_W-1:0]   dac_data_o,
   output logic                sample_stb_o
);

   localparam int unsigned          DEPTH     = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]     LVL_FULL  = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]     LVL_ZERO  = {(FIFO_AW+1){1'b0}};
   localparam logic [FIFO_AW:0]     LVL_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0]   PTR_ZERO  = {FIFO_AW{1'b0}};
   localparam logic [FIFO_AW-1:0]   PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [CLKDIV_W-1:0]  CNT_ZERO  = {CLKDIV_W{1'b0}};
   localparam logic [CLKDIV_W-1:0]  CNT_ONE   = {{(CLKDIV_W-1){1'b0}}, 1'b1};

   logic [CLKDIV_W-1:0] cnt_q, cnt_d;
   logic                tick_q, tick_d;
   logic [FIFO_AW-1:0]  wptr_q, wptr_d;
   logic [FIFO_AW-1:0]  rptr_q, rptr_d;
   logic [FIFO_AW:0]    level_q, level_d;
   logic                underrun_q, underrun_d;
   logic                overflow_q, overflow_d;
   logic [DATA_W-1:0]   dac_data_q, dac_data_d;
   logic                stb_q, stb_d;
   logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

   logic full_s, empty_s, push_s, pop_s;
   logic underrun_set_s, overflow_set_s;

   // Status derived from the registered level; full gates writes for the whole cycle.
   always_comb begin
      full_s  = (level_q == LVL_FULL);
      empty_s = (level_q == LVL_ZERO);
      push_s  = wr_i & ~full_s & ~flush_i;
      pop_s   = tick_q & ~empty_s & ~flush_i;
   end

   // Sample-tick divider; >= compare keeps the counter from running past a lowered clkdiv.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (!en_i) begin
         cnt_d  = CNT_ZERO;
         tick_d = 1'b0;
      end else if (cnt_q >= clkdiv_i) begin
         cnt_d  = CNT_ZERO;
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + CNT_ONE;
         tick_d = 1'b0;
      end
   end

   // FIFO pointer and level bookkeeping; flush overrides push and pop.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (flush_i) begin
         wptr_d  = PTR_ZERO;
         rptr_d  = PTR_ZERO;
         level_d = LVL_ZERO;
      end else begin
         if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
         end else begin
            rptr_d = rptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // DAC code update on each tick, plus the sticky flags where a set beats a clear.
   always_comb begin
      dac_data_d     = dac_data_q;
      stb_d          = 1'b0;
      underrun_set_s = 1'b0;
      overflow_set_s = wr_i & full_s;
      if (tick_q && !flush_i) begin
         stb_d = 1'b1;
         if (!empty_s) begin
            dac_data_d = mem_q[rptr_q];
         end else begin
            underrun_set_s = 1'b1;
            if (mode_i) begin
               dac_data_d = IDLE_CODE;
            end else begin
               dac_data_d = dac_data_q;
            end
         end
      end else begin
         stb_d = 1'b0;
      end
      underrun_d = underrun_set_s | (underrun_q & ~flags_clr_i);
      overflow_d = overflow_set_s | (overflow_q & ~flags_clr_i);
   end

   // Sample storage; contents are meaningless once the pointers are cleared.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= CNT_ZERO;
         tick_q     <= 1'b0;
         wptr_q     <= PTR_ZERO;
         rptr_q     <= PTR_ZERO;
         level_q    <= LVL_ZERO;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         dac_data_q <= IDLE_CODE;
         stb_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tick_q     <= tick_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
         dac_data_q <= dac_data_d;
         stb_q      <= stb_d;
      end
   end

   assign full_o       = full_s;
   assign empty_o      = empty_s;
   assign level_o      = level_q;
   assign low_o        = (level_q < fifo_threshold_i);
   assign underrun_o   = underrun_q;
   assign overflow_o   = overflow_q;
   assign dac_en_o     = en_i;
   assign dac_rst_o    = rst_i;
   assign dac_data_o   = dac_data_q;
   assign sample_stb_o = stb_q;

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Randomised bench for dac_sample_streamer: a queue-based reference model is
// compared every cycle, with directed scenarios pinning hand-computed values.
module tb_dac_sample_streamer;

   localparam int DATA_W   = 10;
   localparam int FIFO_AW  = 5;
   localparam int CLKDIV_W = 20;
   localparam int DEPTH    = 32;
   localparam logic [DATA_W-1:0] IDLE = 10'h000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en = 1'b0, mode = 1'b0, wr = 1'b0, flush = 1'b0, flags_clr = 1'b0;
   logic [CLKDIV_W-1:0] clkdiv = 20'd3;
   logic [FIFO_AW:0]    thr = 6'd0;
   logic [DATA_W-1:0]   wdata = 10'd0;

   logic                full, empty, low, underrun, overflow, dac_en, dac_rst, stb;
   logic [FIFO_AW:0]    level;
   logic [DATA_W-1:0]   dac_data;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] m_q [$];
   logic [DATA_W-1:0] m_data;
   bit                m_stb, m_ur, m_ov, m_tick;
   int                m_cnt;

   always #5 clk = ~clk;

   dac_sample_streamer #(
      .DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .CLKDIV_W(CLKDIV_W), .IDLE_CODE(IDLE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .clkdiv_i(clkdiv),
      .fifo_threshold_i(thr), .wr_i(wr), .wdata_i(wdata), .flush_i(flush),
      .flags_clr_i(flags_clr), .full_o(full), .empty_o(empty), .level_o(level),
      .low_o(low), .underrun_o(underrun), .overflow_o(overflow), .dac_en_o(dac_en),
      .dac_rst_o(dac_rst), .dac_data_o(dac_data), .sample_stb_o(stb)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the reference: a sample queue plus a tick every clkdiv+1 enabled cycles.
   task automatic model_step();
      int lvl;
      bit tk;
      lvl = m_q.size();
      if (rst) begin
         m_q.delete();
         m_cnt = 0; m_tick = 1'b0; m_data = IDLE; m_stb = 1'b0; m_ur = 1'b0; m_ov = 1'b0;
      end else begin
         tk    = m_tick && !flush;
         m_stb = tk;
         if (tk && lvl > 0) m_data = m_q[0];
         else if (tk && mode) m_data = IDLE;
         m_ur = (tk && lvl == 0) || (m_ur && !flags_clr);
         m_ov = (wr && lvl == DEPTH) || (m_ov && !flags_clr);
         if (flush) begin
            m_q.delete();
         end else begin
            if (tk && lvl > 0) m_q.delete(0);
            if (wr && lvl < DEPTH) m_q.push_back(wdata);
         end
         if (!en) begin
            m_cnt = 0; m_tick = 1'b0;
         end else if (m_cnt >= int'(clkdiv)) begin
            m_cnt = 0; m_tick = 1'b1;
         end else begin
            m_cnt++; m_tick = 1'b0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("dac_data", dac_data, m_data);
         chk("sample_stb", stb, m_stb);
         chk("level", level, m_q.size());
         chk("full", full, m_q.size() == DEPTH);
         chk("empty", empty, m_q.size() == 0);
         chk("low", low, m_q.size() < int'(thr));
         chk("underrun", underrun, m_ur);
         chk("overflow", overflow, m_ov);
         chk("dac_en", dac_en, en);
         chk("dac_rst", dac_rst, rst);
      end
   end

   task automatic pulse_flush();
      flush = 1'b1; @(negedge clk); flush = 1'b0;
   endtask

   task automatic pulse_clr();
      flags_clr = 1'b1; @(negedge clk); flags_clr = 1'b0;
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      wr = 1'b1; wdata = d; @(negedge clk); wr = 1'b0;
   endtask

   initial begin
      int cyc;
      int times [$];
      logic [DATA_W-1:0] got [$];
      bit hit;

      repeat (3) @(negedge clk);
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_data", dac_data, IDLE);
      chk("rst_stb", stb, 0);
      rst = 1'b0;

      // T1: three samples released every 4 cycles
      clkdiv = 20'd3;
      push(10'h001); push(10'h002); push(10'h003);
      en = 1'b1;
      cyc = 0;
      while (got.size() < 3 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (stb) begin
            got.push_back(dac_data);
            times.push_back(cyc);
         end
      end
      chk("t1_count", got.size(), 3);
      for (int i = 0; i < got.size(); i++) chk("t1_data", got[i], i + 1);
      for (int i = 1; i < times.size(); i++) chk("t1_spacing", times[i] - times[i-1], 4);
      if (times.size() > 0) chk("t1_first_cycle", times[0], 5);
      en = 1'b0;
      @(negedge clk);
      pulse_clr();

      // T2: overfill with the streamer stopped
      pulse_flush();
      for (int i = 0; i < 33; i++) push(10'($urandom_range(1023, 0)));
      chk("t2_level", level, 32);
      chk("t2_full", full, 1);
      chk("t2_overflow", overflow, 1);
      pulse_clr();
      chk("t2_overflow_clr", overflow, 0);
      chk("t2_level_kept", level, 32);

      // T3: underrun holds last code, then idle code
      pulse_flush();
      push(10'h155);
      mode = 1'b0; clkdiv = 20'd1; en = 1'b1;
      repeat (12) @(negedge clk);
      chk("t3_hold", dac_data, 10'h155);
      chk("t3_underrun", underrun, 1);
      mode = 1'b1;
      repeat (6) @(negedge clk);
      chk("t3_idle", dac_data, IDLE);
      en = 1'b0; mode = 1'b0;
      @(negedge clk);
      pulse_clr();
      chk("t3_underrun_clr", underrun, 0);

      // T4: tick every cycle with a write every cycle keeps the level steady
      pulse_flush();
      for (int i = 0; i < 4; i++) push(10'(i + 5));
      clkdiv = 20'd0; en = 1'b1; wr = 1'b1;
      for (int i = 0; i < 30; i++) begin
         wdata = 10'($urandom_range(1023, 0));
         @(negedge clk);
         chk("t4_level", level, 5);
      end
      wr = 1'b0;
      chk("t4_no_underrun", underrun, 0);
      en = 1'b0;
      @(negedge clk);

      // T5: low watermark and flush beating a write
      pulse_flush();
      for (int i = 0; i < 10; i++) push(10'(i));
      thr = 6'd11; #1;
      chk("t5_level10", level, 10);
      chk("t5_low_on", low, 1);
      push(10'h3ff); #1;
      chk("t5_level11", level, 11);
      chk("t5_low_off", low, 0);
      flush = 1'b1; wr = 1'b1; @(negedge clk); flush = 1'b0; wr = 1'b0;
      chk("t5_flush_level", level, 0);
      chk("t5_flush_empty", empty, 1);
      thr = 6'd0; #1;
      chk("t5_thr0", low, 0);
      for (int i = 0; i < 32; i++) push(10'(i));
      thr = 6'd33; #1;
      chk("t5_thr33_full", low, 1);
      thr = 6'd32; #1;
      chk("t5_thr32_full", low, 0);

      // Random regime
      pulse_flush();
      pulse_clr();
      for (int i = 0; i < 2000; i++) begin
         if (i % 64 == 0) begin
            en     = ($urandom_range(3, 0) != 0);
            clkdiv = 20'($urandom_range(6, 0));
            mode   = 1'($urandom_range(1, 0));
            thr    = 6'($urandom_range(40, 0));
         end
         wr        = ($urandom_range(2, 0) != 0);
         wdata     = 10'($urandom_range(1023, 0));
         flush     = ($urandom_range(96, 0) == 0);
         flags_clr = ($urandom_range(52, 0) == 0);
         @(negedge clk);
      end
      wr = 1'b0; flush = 1'b0; flags_clr = 1'b0; en = 1'b0;
      @(negedge clk);

      // T6: asynchronous reset mid-stream
      pulse_flush();
      for (int i = 0; i < 10; i++) push(10'(10'h100 + i));
      clkdiv = 20'd1; en = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge clk);
         if (m_q.size() == 7) hit = 1'b1;
      end
      chk("t6_pre_level", level, 7);
      rst = 1'b1; #1;
      chk("t6_level", level, 0);
      chk("t6_empty", empty, 1);
      chk("t6_data", dac_data, IDLE);
      chk("t6_stb", stb, 0);
      chk("t6_underrun", underrun, 0);
      chk("t6_overflow", overflow, 0);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
